// File: rtl/sad_result_collector.sv
// sad_result_collector
//
// Sits behind the block-matching writeback stage. Tracks the running minimum
// SAD across one search window of SEARCH_W x SEARCH_H candidates, derives the
// (x, y) window position of the best match, and holds a registered result for
// the host until it is taken with a valid/ready handshake.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   start                    one-cycle pulse in IDLE, arms a new window
//   wb_valid/wb_sad/wb_addr  candidate stream from writeback
//   res_ready                host accepts the result
//   busy                     high while collecting
//   res_valid                result registers hold a finished window
//   min_sad/min_addr         best SAD of the window and its address
//   min_x/min_y              column/row of the best candidate
//   cand_count               candidates accepted in the current/last window
//   overrun                  sticky: candidate seen while not collecting
//
// state   | meaning
// --------+--------------------------------------------------------
// IDLE    | waiting for start; candidates here flag overrun
// COLLECT | accepting candidates, tracking the running minimum
// REPORT  | result held with res_valid until res_ready

module sad_result_collector #(
    parameter int SEARCH_W = 61,
    parameter int SEARCH_H = 61,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              wb_valid,
    input  logic [DATA_W-1:0] wb_sad,
    input  logic [DATA_W-1:0] wb_addr,
    input  logic              res_ready,
    output logic              busy,
    output logic              res_valid,
    output logic [DATA_W-1:0] min_sad,
    output logic [DATA_W-1:0] min_addr,
    output logic [DATA_W-1:0] min_x,
    output logic [DATA_W-1:0] min_y,
    output logic [DATA_W-1:0] cand_count,
    output logic              overrun
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        REPORT  = 2'd2
    } state_t;

    localparam logic [DATA_W-1:0] X_LAST = DATA_W'(SEARCH_W - 1);
    localparam logic [DATA_W-1:0] Y_LAST = DATA_W'(SEARCH_H - 1);

    state_t            state;
    logic [DATA_W-1:0] best_sad;
    logic [DATA_W-1:0] best_addr;
    logic [DATA_W-1:0] best_x;
    logic [DATA_W-1:0] best_y;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic [DATA_W-1:0] count;

    // The first candidate is always taken so an all-ones window still reports
    // candidate 0 rather than an undefined address.
    logic take_cand;
    logic last_cand;

    assign take_cand = (count == '0) || (wb_sad < best_sad);
    assign last_cand = (x == X_LAST) && (y == Y_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            best_sad   <= '1;
            best_addr  <= '0;
            best_x     <= '0;
            best_y     <= '0;
            x          <= '0;
            y          <= '0;
            count      <= '0;
            busy       <= 1'b0;
            res_valid  <= 1'b0;
            min_sad    <= '0;
            min_addr   <= '0;
            min_x      <= '0;
            min_y      <= '0;
            cand_count <= '0;
            overrun    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= COLLECT;
                        busy       <= 1'b1;
                        best_sad   <= '1;
                        best_addr  <= '0;
                        best_x     <= '0;
                        best_y     <= '0;
                        x          <= '0;
                        y          <= '0;
                        count      <= '0;
                        cand_count <= '0;
                        overrun    <= 1'b0;
                    end
                    // A stray candidate on the start edge is still a violation.
                    if (wb_valid) begin
                        overrun <= 1'b1;
                    end
                end

                COLLECT: begin
                    if (wb_valid) begin
                        if (take_cand) begin
                            best_sad  <= wb_sad;
                            best_addr <= wb_addr;
                            best_x    <= x;
                            best_y    <= y;
                        end
                        count      <= count + 1'b1;
                        cand_count <= count + 1'b1;
                        if (x == X_LAST) begin
                            x <= '0;
                            y <= y + 1'b1;
                        end else begin
                            x <= x + 1'b1;
                        end
                        // The final candidate participates in the compare, so
                        // the snapshot picks between it and the running best.
                        if (last_cand) begin
                            state     <= REPORT;
                            busy      <= 1'b0;
                            res_valid <= 1'b1;
                            min_sad   <= take_cand ? wb_sad  : best_sad;
                            min_addr  <= take_cand ? wb_addr : best_addr;
                            min_x     <= take_cand ? x       : best_x;
                            min_y     <= take_cand ? y       : best_y;
                        end
                    end
                end

                REPORT: begin
                    if (wb_valid) begin
                        overrun <= 1'b1;
                    end
                    if (res_ready) begin
                        state     <= IDLE;
                        res_valid <= 1'b0;
                    end
                end

                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sad_result_collector.sv
module tb_sad_result_collector;

    localparam int DATA_W = 32;

    logic              clk;
    logic              rst;
    logic              start;
    logic              wb_valid;
    logic [DATA_W-1:0] wb_sad;
    logic [DATA_W-1:0] wb_addr;
    logic              res_ready;
    logic              busy;
    logic              res_valid;
    logic [DATA_W-1:0] min_sad;
    logic [DATA_W-1:0] min_addr;
    logic [DATA_W-1:0] min_x;
    logic [DATA_W-1:0] min_y;
    logic [DATA_W-1:0] cand_count;
    logic              overrun;

    int checks;
    int errors;

    sad_result_collector #(
        .SEARCH_W(3),
        .SEARCH_H(2),
        .DATA_W  (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .wb_valid  (wb_valid),
        .wb_sad    (wb_sad),
        .wb_addr   (wb_addr),
        .res_ready (res_ready),
        .busy      (busy),
        .res_valid (res_valid),
        .min_sad   (min_sad),
        .min_addr  (min_addr),
        .min_x     (min_x),
        .min_y     (min_y),
        .cand_count(cand_count),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [DATA_W-1:0] sad, input logic [DATA_W-1:0] addr, input int gap);
        wb_valid = 1'b1;
        wb_sad   = sad;
        wb_addr  = addr;
        step();
        wb_valid = 1'b0;
        repeat (gap) step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [DATA_W-1:0] e_sad, input logic [DATA_W-1:0] e_addr,
                                input logic [DATA_W-1:0] e_x, input logic [DATA_W-1:0] e_y);
        chk({tag, "_res_valid"}, {31'd0, res_valid}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_min_sad"}, min_sad, e_sad);
        chk({tag, "_min_addr"}, min_addr, e_addr);
        chk({tag, "_min_x"}, min_x, e_x);
        chk({tag, "_min_y"}, min_y, e_y);
        chk({tag, "_cand_count"}, cand_count, 32'd6);
    endtask

    task automatic handshake(input string tag);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk({tag, "_hs_res_valid"}, {31'd0, res_valid}, 32'd0);
        chk({tag, "_hs_busy"}, {31'd0, busy}, 32'd0);
    endtask

    logic [DATA_W-1:0] sads1 [6];
    int                gaps  [6];

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        wb_valid  = 1'b0;
        wb_sad    = '0;
        wb_addr   = '0;
        res_ready = 1'b0;
        sads1     = '{32'd50, 32'd40, 32'd45, 32'd40, 32'd60, 32'd41};
        gaps      = '{0, 1, 2, 3, 0, 2};

        // Reset state
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("rst_min_sad", min_sad, 32'd0);
        chk("rst_cand_count", cand_count, 32'd0);
        chk("rst_overrun", {31'd0, overrun}, 32'd0);
        step();
        rst = 1'b0;
        step();

        // Window 1: no gaps, tie keeps the earlier 40
        pulse_start();
        chk("w1_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 5; i++) send(sads1[i], 32'h100 + i, 0);
        chk("w1_pre_res_valid", {31'd0, res_valid}, 32'd0);
        chk("w1_pre_count", cand_count, 32'd5);
        send(sads1[5], 32'h105, 0);
        check_result("w1", 32'd40, 32'h101, 32'd1, 32'd0);
        handshake("w1");
        chk("w1_hold_min_sad", min_sad, 32'd40);

        // Window 2: same stream with gaps, result held under backpressure
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            send(sads1[i], 32'h100 + i, (i == 5) ? 0 : gaps[i]);
            if (i == 2) chk("w2_mid_count", cand_count, 32'd3);
        end
        for (int c = 0; c < 5; c++) begin
            check_result("w2_stall", 32'd40, 32'h101, 32'd1, 32'd0);
            step();
        end
        handshake("w2");

        // Window 3: minimum on the last candidate
        pulse_start();
        send(32'd9, 32'h200, 0);
        send(32'd8, 32'h201, 0);
        send(32'd7, 32'h202, 0);
        send(32'd6, 32'h203, 1);
        send(32'd5, 32'h204, 0);
        send(32'd1, 32'h205, 0);
        check_result("w3", 32'd1, 32'h205, 32'd2, 32'd1);
        handshake("w3");

        // Window 4: all ones reports the first candidate
        pulse_start();
        for (int i = 0; i < 6; i++) send(32'hFFFF_FFFF, 32'h300 + i, 0);
        check_result("w4", 32'hFFFF_FFFF, 32'h300, 32'd0, 32'd0);
        handshake("w4");

        // Overrun in IDLE, cleared by start, set again in REPORT
        send(32'd0, 32'h999, 0);
        chk("ovr_idle", {31'd0, overrun}, 32'd1);
        chk("ovr_idle_res_valid", {31'd0, res_valid}, 32'd0);
        chk("ovr_idle_min_sad", min_sad, 32'hFFFF_FFFF);
        chk("ovr_idle_min_addr", min_addr, 32'h300);
        chk("ovr_idle_count", cand_count, 32'd6);
        pulse_start();
        chk("ovr_clr_start", {31'd0, overrun}, 32'd0);
        for (int i = 0; i < 6; i++) send(sads1[i], 32'h100 + i, 0);
        send(32'd0, 32'h999, 0);
        chk("ovr_report", {31'd0, overrun}, 32'd1);
        check_result("ovr_report", 32'd40, 32'h101, 32'd1, 32'd0);
        handshake("ovr");
        chk("ovr_sticky", {31'd0, overrun}, 32'd1);
        pulse_start();
        chk("ovr_clr2", {31'd0, overrun}, 32'd0);

        // Async reset mid-collect, then an independent window
        send(32'd5, 32'h500, 0);
        send(32'd4, 32'h501, 0);
        send(32'd3, 32'h502, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_res_valid", {31'd0, res_valid}, 32'd0);
        chk("arst_min_sad", min_sad, 32'd0);
        chk("arst_min_addr", min_addr, 32'd0);
        chk("arst_cand_count", cand_count, 32'd0);
        chk("arst_overrun", {31'd0, overrun}, 32'd0);
        step();
        rst = 1'b0;
        step();
        pulse_start();
        send(32'd7, 32'h400, 0);
        send(32'd3, 32'h401, 0);
        send(32'd5, 32'h402, 0);
        send(32'd3, 32'h403, 0);
        send(32'd2, 32'h404, 0);
        send(32'd9, 32'h405, 0);
        check_result("w6", 32'd2, 32'h404, 32'd1, 32'd1);
        handshake("w6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sad_result_collector.md
Name: sad_result_collector

Overview:
- Downstream of the pipelined block-matching processor's writeback stage.
- Consumes the per-candidate SAD/address stream from WB and tracks the running minimum over one full search window.
- Derives the (X, Y) window coordinates of the best match and presents one registered result to the display/host side with a valid/ready handshake.
- Flags stream protocol violations with a sticky overrun bit.

Parameters:
- SEARCH_W, 61, candidate positions per row (columns in the search window).
- SEARCH_H, 61, candidate rows in the search window.
- DATA_W, 32, width of SAD, address and coordinate fields.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; arms collection of a new window.
- wb_valid  in  1  WB stage presents a candidate this cycle.
- wb_sad  in  DATA_W  SAD of the presented candidate, unsigned.
- wb_addr  in  DATA_W  memory address of the presented candidate.
- res_ready  in  1  consumer accepts the result.
- busy  out  1  high while in COLLECT.
- res_valid  out  1  result registers hold a finished window.
- min_sad  out  DATA_W  minimum SAD of the window.
- min_addr  out  DATA_W  address of the minimum.
- min_x  out  DATA_W  column index of the minimum, 0..SEARCH_W-1.
- min_y  out  DATA_W  row index of the minimum, 0..SEARCH_H-1.
- cand_count  out  DATA_W  candidates accepted in the current or last window.
- overrun  out  1  sticky: wb_valid seen outside COLLECT.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset state: IDLE. All outputs 0. Internal best_sad = all ones; x, y, count = 0.
- States: IDLE, COLLECT, REPORT.
- IDLE:
  - start=1 -> COLLECT next edge.
  - On that edge: best_sad <= all ones; best_addr, best_x, best_y, x, y, count <= 0; overrun <= 0; cand_count <= 0.
- COLLECT:
  - busy=1; start is ignored.
  - Each edge with wb_valid=1:
    - If wb_sad < best_sad (unsigned, strict), capture best_sad, best_addr, best_x <= x, best_y <= y. Ties keep the earlier candidate.
    - count++ and cand_count follows count.
    - x++; at x==SEARCH_W-1, x <= 0 and y++.
  - wb_valid=0: no change; gaps are allowed anywhere in the stream.
  - When the accepted candidate is the last one (x==SEARCH_W-1 && y==SEARCH_H-1):
    - Snapshot the final minimum into min_sad/min_addr/min_x/min_y on that same edge. The last candidate is included in the compare.
    - Go to REPORT; res_valid=1 from the next cycle.
- Latency: final candidate accepted on edge N -> res_valid and result outputs valid after edge N.
- REPORT:
  - res_valid held high; min_* and cand_count stable until handshake.
  - Edge with res_valid && res_ready -> IDLE; res_valid low after that edge; min_* retain their values.
  - start in REPORT is ignored, including on the handshake cycle; the producer must re-pulse start in IDLE.
- overrun: wb_valid=1 in IDLE or REPORT sets overrun. The candidate is discarded and no other state changes. overrun is cleared only by start in IDLE or by rst.
- All compares and counters are unsigned DATA_W; count cannot wrap for legal parameters.
- rst asserted mid-COLLECT or mid-REPORT -> immediate return to reset state, no result emitted.
- A window whose every SAD is all ones still reports candidate 0 (addr/x/y of the first candidate, min_sad=all ones). To guarantee this, the first candidate is always captured, whatever its SAD.

Test Plan:
- SEARCH_W=3, SEARCH_H=2; reset, start, stream SAD 50,40,45,40,60,41 at addr 0x100..0x105, no gaps -> res_valid one cycle after the 6th; min_sad=40, min_addr=0x101, min_x=1, min_y=0 (tie keeps first), cand_count=6.
- Same stream with wb_valid gaps of 0–3 cycles, res_ready=0 for 5 cycles -> identical result held stable all 5 cycles; res_valid drops the cycle after res_ready=1; busy low.
- Minimum on the last candidate (SADs 9,8,7,6,5,1) -> min_sad=1, min_x=2, min_y=1, min_addr of the 6th.
- All SADs 0xFFFFFFFF -> min_sad=0xFFFFFFFF, min_x=0, min_y=0, min_addr=first address.
- wb_valid pulse in IDLE and another in REPORT -> overrun=1 and result unchanged; next start clears overrun to 0.
- rst asserted after 3 candidates -> all outputs 0 asynchronously, state IDLE; a fresh start and 6 candidates produce a correct, independent result.
